// File: rtl/seg7_scan_decoder.sv
// Passive monitor for a multiplexed 7-segment bus: settles, decodes and frames the digits being shown.
// Latency: capture STABLE_CYCLES-1 edges after the FSM first sees a pattern, frame one edge later; no backpressure (observer only).
module seg7_scan_decoder #(
   parameter int NDIG          = 8,
   parameter int STABLE_CYCLES = 4
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [NDIG-1:0]     an_in,
   input  logic [7:0]          seg_in,
   output logic [4*NDIG-1:0]   value,
   output logic [NDIG-1:0]     dp,
   output logic                frame_valid,
   output logic                frame_err,
   output logic                digit_stb
);

   localparam int         IW = (NDIG > 1) ? $clog2(NDIG) : 1;
   localparam logic [7:0] SC = 8'(STABLE_CYCLES);

   typedef enum logic [1:0] {IDLE, SETTLE, CAPTURED} state_t;

   state_t            state;
   logic [NDIG-1:0]   an_s, an_p;
   logic [7:0]        seg_s, seg_p;
   logic [7:0]        cnt;
   logic [NDIG-1:0]   seen, bad, shadow_dp;
   logic [4*NDIG-1:0] shadow;

   logic [IW-1:0]     idx;
   int unsigned       nlow;
   logic              sel;
   logic              changed;
   logic              capture;
   logic [3:0]        nib;
   logic              nib_ok;

   // A digit is selected only when exactly one anode is driven low.
   always_comb begin
      idx  = '0;
      nlow = 0;
      for (int i = 0; i < NDIG; i++) begin
         if (!an_s[i]) begin
            idx  = IW'(i);
            nlow = nlow + 1;
         end
      end
      sel = (nlow == 1);
   end

   assign changed = ({an_s, seg_s} != {an_p, seg_p});

   always_comb begin
      nib    = 4'h0;
      nib_ok = 1'b1;
      case ({1'b1, seg_s[6:0]})
         8'hC0: nib = 4'h0;
         8'hF9: nib = 4'h1;
         8'hA4: nib = 4'h2;
         8'hB0: nib = 4'h3;
         8'h99: nib = 4'h4;
         8'h92: nib = 4'h5;
         8'h82: nib = 4'h6;
         8'hF8: nib = 4'h7;
         8'h80: nib = 4'h8;
         8'h90: nib = 4'h9;
         8'h88: nib = 4'hA;
         8'h83: nib = 4'hB;
         8'hC6: nib = 4'hC;
         8'hA1: nib = 4'hD;
         8'h86: nib = 4'hE;
         8'h8E: nib = 4'hF;
         default: nib_ok = 1'b0;
      endcase
   end

   // A fresh pattern counts as the first stable sample, so S=1 captures on the change itself.
   always_comb begin
      capture = 1'b0;
      if (changed)
         capture = sel && (SC == 8'd1);
      else if (state == SETTLE)
         capture = (cnt + 8'd1 == SC);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= IDLE;
         an_s        <= '0;
         an_p        <= '0;
         seg_s       <= '0;
         seg_p       <= '0;
         cnt         <= '0;
         seen        <= '0;
         bad         <= '0;
         shadow      <= '0;
         shadow_dp   <= '0;
         value       <= '0;
         dp          <= '0;
         frame_valid <= 1'b0;
         frame_err   <= 1'b0;
         digit_stb   <= 1'b0;
      end else begin
         an_s        <= an_in;
         seg_s       <= seg_in;
         an_p        <= an_s;
         seg_p       <= seg_s;
         digit_stb   <= capture;
         frame_valid <= &seen;

         if (changed) begin
            if (!sel) begin
               state <= IDLE;
               cnt   <= '0;
            end else begin
               state <= capture ? CAPTURED : SETTLE;
               cnt   <= 8'd1;
            end
         end else if (state == SETTLE) begin
            cnt <= cnt + 8'd1;
            if (capture)
               state <= CAPTURED;
         end

         // Completion publishes the old shadow; a same-edge capture lands in the new frame.
         if (&seen) begin
            value     <= shadow;
            dp        <= shadow_dp;
            frame_err <= |bad;
            seen      <= '0;
            bad       <= '0;
         end
         if (capture) begin
            seen[idx]                  <= 1'b1;
            bad[idx]                   <= ~nib_ok;
            shadow[{idx, 2'b00} +: 4]  <= nib;
            shadow_dp[idx]             <= ~seg_s[7];
         end
      end
   end

endmodule
